// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: registered result/flags plus a one-cycle acc_we strobe.
// Optional iterative MUL on opcode 111 when SEQ_ALU_MUL_EN is defined; otherwise opcode 111 is PASS_B.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             acc_we,
    output logic             busy,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic [WIDTH:0]   ext;

`ifdef SEQ_ALU_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`endif

    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_cy  = 1'b0;
        unique case (op)
            3'b000: begin
                ext     = {1'b0, a} + {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_cy  = ext[WIDTH];
            end
            3'b001: begin
                // Bit WIDTH of the extended difference is the borrow (a < b).
                ext     = {1'b0, a} - {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_cy  = ext[WIDTH];
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = a ^ b;
            3'b101: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_cy  = a[WIDTH-1];
            end
            3'b110: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_cy  = a[0];
            end
            default: begin
`ifdef SEQ_ALU_MUL_EN
                alu_res = '0;
`else
                alu_res = b;
`endif
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign prod_step = prod_q + (mplr_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op == 3'b111) begin
                        state_d = EXEC;
                        mcand_d = {{WIDTH{1'b0}}, a};
                        mplr_d  = b;
                        prod_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_cy;
                    end
`else
                    state_d  = DONE;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    carry_d  = alu_cy;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            EXEC: begin
                // The final step's sum goes straight into result so DONE follows the WIDTH-th step.
                prod_d  = prod_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = prod_step[WIDTH-1:0];
                    zero_d   = (prod_step[WIDTH-1:0] == '0);
                    carry_d  = |prod_step[2*WIDTH-1:WIDTH];
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign acc_we = (state_q == DONE);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors push expected results, a negedge monitor pops on acc_we.
// Opcode 111 vectors follow SEQ_ALU_MUL_EN (MUL when defined, PASS_B otherwise).
module tb_seq_alu;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result;
    logic         acc_we, busy, zero, carry;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .acc_we (acc_we),
        .busy   (busy),
        .zero   (zero),
        .carry  (carry)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    exp_t cur;
    always @(negedge clk) begin
        if (rst === 1'b0 && acc_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_acc_we", {31'd0, acc_we}, 32'd0);
            end else begin
                cur = sb.pop_front();
                check("result", {24'd0, result}, {24'd0, cur.res});
                check("zero",   {31'd0, zero},   {31'd0, cur.z});
                check("carry",  {31'd0, carry},  {31'd0, cur.c});
            end
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] er, input logic ez, input logic ec,
                       input int unsigned lat, input bit intrude);
        int unsigned cyc = 0, busy_n = 0, we_n = 0, we_at = 0;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        sb.push_back('{er, ez, ec});
        do begin
            @(negedge clk);
            cyc++;
            if (intrude && cyc >= 3 && cyc <= 5) begin
                start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0; a = ~va; b = ~vb;
            end
            if (busy === 1'b1) busy_n++;
            if (acc_we === 1'b1) begin
                we_n++;
                we_at = cyc;
            end
        end while (busy === 1'b1 && cyc < 40);
        check("busy_cycles", busy_n, lat);
        check("acc_we_count", we_n, 1);
        check("acc_we_latency", we_at, lat);
        check("result_held", {24'd0, result}, {24'd0, er});
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_result", {24'd0, result}, 32'd0);
        check("arst_flags", {29'd0, acc_we, busy, zero, carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_flags", {29'd0, acc_we, busy, zero, carry}, 32'd0);
        rst = 1'b0;

        run(3'b000, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1, 0);
        run(3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1, 0);
        run(3'b001, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b1, 1, 0);
        async_reset_check();
        run(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1, 0);
        async_reset_check();
        run(3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, 0);
        run(3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1, 0);
        run(3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1, 0);
        run(3'b100, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1, 0);
        run(3'b101, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1, 0);
        run(3'b101, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0, 1, 0);
        run(3'b110, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 1, 0);
        run(3'b110, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1, 0);

`ifdef SEQ_ALU_MUL_EN
        run(3'b111, 8'd12, 8'd11, 8'd132, 1'b0, 1'b0, W + 1, 0);
        run(3'b111, 8'd16, 8'd16, 8'd0, 1'b1, 1'b1, W + 1, 0);
        run(3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, W + 1, 0);
        run(3'b111, 8'd7, 8'd9, 8'd63, 1'b0, 1'b0, W + 1, 1);
        begin
            int unsigned we_n = 0;
            @(negedge clk);
            op = 3'b111; a = 8'd3; b = 8'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("abort_result", {24'd0, result}, 32'd0);
            check("abort_flags", {29'd0, acc_we, busy, zero, carry}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (acc_we === 1'b1) we_n++;
            end
            check("abort_no_acc_we", we_n, 0);
        end
        run(3'b000, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1, 0);
`else
        run(3'b111, 8'h3C, 8'hA5, 8'hA5, 1'b0, 1'b0, 1, 0);
        run(3'b111, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
